// File: rtl/vga_sync_rx_pkg.sv
// Types and widths private to the VGA loopback receiver.
package vga_sync_rx_pkg;
    localparam int COMP_W  = 4;
    localparam int RGB_W   = 3 * COMP_W;
    localparam int COORD_W = 11;
    localparam int SUM_W   = 16;
    localparam int TO_W    = 12;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;
endpackage

// File: rtl/vga_timing_pkg.sv
// Nominal 640x480@60 VGA timing shared by the transmitter and the loopback receiver.
package vga_timing_pkg;
    localparam int   H_SYNC      = 96;
    localparam int   H_BP        = 48;
    localparam int   H_ACT       = 640;
    localparam int   H_TOTAL     = 800;
    localparam int   V_SYNC      = 2;
    localparam int   V_BP        = 33;
    localparam int   V_ACT       = 480;
    localparam int   V_TOTAL     = 525;
    localparam logic SYNC_POL    = 1'b0;
    localparam int   LOCK_FRAMES = 2;
endpackage

// File: rtl/vga_sync_rx_if.sv
// VGA connector signals: syncs plus 4-bit colour components.
interface vga_sync_rx_if;
    import vga_sync_rx_pkg::*;

    logic              hs;
    logic              vs;
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;

    modport master (output hs, vs, r, g, b);
    modport slave  (input  hs, vs, r, g, b);
endinterface

// File: rtl/vga_sync_edge.sv
// Two-flop sampler for an asynchronous-to-us sync pin plus a detector for the
// first sampled clock of the asserted level (polarity set by SYNC_POL).
module vga_sync_edge #(
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_pin,
    output logic start
);
    logic sync_r1;
    logic sync_r2;

    // Sample the pin twice; reset to the idle level so no false start appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r1 <= ~SYNC_POL;
            sync_r2 <= ~SYNC_POL;
        end else begin
            sync_r1 <= sync_pin;
            sync_r2 <= sync_r1;
        end
    end

    assign start = (sync_r1 == SYNC_POL) && (sync_r2 != SYNC_POL);
endmodule

// File: rtl/vga_sync_rx.sv
// VGA loopback monitor: recovers pixel coordinates from hsync/vsync, checks
// line/frame lengths, tracks lock, captures a probe pixel and sums each frame.
module vga_sync_rx
    import vga_sync_rx_pkg::*;
#(
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int   H_BP        = vga_timing_pkg::H_BP,
    parameter int   H_ACT       = vga_timing_pkg::H_ACT,
    parameter int   H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int   V_BP        = vga_timing_pkg::V_BP,
    parameter int   V_ACT       = vga_timing_pkg::V_ACT,
    parameter int   V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter logic SYNC_POL    = vga_timing_pkg::SYNC_POL,
    parameter int   LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_sync_rx_if.slave       vga,
    input  logic [COORD_W-1:0] i_probe_x,
    input  logic [COORD_W-1:0] i_probe_y,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_de,
    output logic               o_locked,
    output logic               o_err_h,
    output logic               o_err_v,
    output logic [RGB_W-1:0]   o_probe_rgb,
    output logic               o_probe_valid,
    output logic [SUM_W-1:0]   o_frame_sum,
    output logic               o_frame_done
);
    localparam logic [COORD_W-1:0] X0     = COORD_W'(H_SYNC + H_BP);
    localparam logic [COORD_W-1:0] X1     = COORD_W'(H_SYNC + H_BP + H_ACT);
    localparam logic [COORD_W-1:0] Y0     = COORD_W'(V_SYNC + V_BP);
    localparam logic [COORD_W-1:0] Y1     = COORD_W'(V_SYNC + V_BP + V_ACT);
    localparam logic [COORD_W:0]   H_LEN  = (COORD_W + 1)'(H_TOTAL);
    localparam logic [COORD_W:0]   V_LEN  = (COORD_W + 1)'(V_TOTAL);
    localparam logic [TO_W-1:0]    TO_MAX = TO_W'(2 * H_TOTAL - 1);
    localparam int                 GW     = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]      G_LAST = GW'(LOCK_FRAMES - 1);

    function automatic logic [COORD_W-1:0] sat_inc_coord(input logic [COORD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic               hs_start;
    logic               vs_start;
    logic [RGB_W-1:0]   rgb_r1;
    logic [RGB_W-1:0]   rgb_r2;
    logic [COORD_W-1:0] h_pos;
    logic [COORD_W-1:0] v_pos;
    logic               vs_pend;
    logic               h_seen;
    logic               v_seen;
    logic [TO_W-1:0]    to_cnt;
    rx_state_t          state;
    rx_state_t          state_next;
    logic [GW-1:0]      good_cnt;
    logic [GW-1:0]      good_next;
    logic [SUM_W-1:0]   acc;

    logic               reload;
    logic               err_h;
    logic               err_v;
    logic               timeout;
    logic               entering_seek;
    logic               de_next;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic               probe_hit;

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_pin (vga.hs),
        .start    (hs_start)
    );

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_pin (vga.vs),
        .start    (vs_start)
    );

    // Colour follows the same two-flop path as the syncs so it stays aligned with h_pos.
    always_ff @(posedge clk) begin
        rgb_r1 <= {vga.r, vga.g, vga.b};
        rgb_r2 <= rgb_r1;
    end

    // A vsync that arrives mid-line waits for the next hsync to restart the frame.
    assign reload        = hs_start && (vs_start || vs_pend);
    assign err_h         = hs_start && h_seen && (({1'b0, h_pos} + 1'b1) != H_LEN);
    assign err_v         = reload && v_seen && (({1'b0, v_pos} + 1'b1) != V_LEN);
    assign timeout       = !hs_start && (to_cnt >= TO_MAX);
    assign entering_seek = (state_next == SEEK) && (state != SEEK);

    assign x_next    = h_pos - X0;
    assign y_next    = v_pos - Y0;
    assign de_next   = (state == LOCKED) && (h_pos >= X0) && (h_pos < X1)
                       && (v_pos >= Y0) && (v_pos < Y1);
    assign probe_hit = de_next && (x_next == i_probe_x) && (y_next == i_probe_y);
    assign o_locked  = (state == LOCKED);

    // Lock FSM next state: only checked reloads count towards lock; timeout overrides all.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        case (state)
            SEEK: begin
                if (vs_start) begin
                    state_next = TRACK;
                    good_next  = '0;
                end
            end
            TRACK: begin
                if (err_h || err_v) begin
                    good_next = '0;
                end else if (reload && v_seen) begin
                    if (good_cnt == G_LAST) begin
                        state_next = LOCKED;
                        good_next  = '0;
                    end else begin
                        good_next = good_cnt + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (err_h || err_v) begin
                    state_next = TRACK;
                    good_next  = '0;
                end
            end
            default: begin
                state_next = SEEK;
                good_next  = '0;
            end
        endcase
        if (timeout) begin
            state_next = SEEK;
            good_next  = '0;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEEK;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    // Position counters, pending vsync, first-event suppression flags and hsync watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_pos   <= '0;
            v_pos   <= '0;
            vs_pend <= 1'b0;
            h_seen  <= 1'b0;
            v_seen  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            h_pos  <= hs_start ? '0 : sat_inc_coord(h_pos);
            to_cnt <= hs_start ? '0 : sat_inc_to(to_cnt);

            if (reload)        v_pos <= '0;
            else if (hs_start) v_pos <= sat_inc_coord(v_pos);

            if (reload)        vs_pend <= 1'b0;
            else if (vs_start) vs_pend <= 1'b1;

            if (entering_seek) h_seen <= 1'b0;
            else if (hs_start) h_seen <= 1'b1;

            if (entering_seek) v_seen <= 1'b0;
            else if (reload)   v_seen <= 1'b1;
        end
    end

    // Registered coordinates, data-enable, error pulses and probe capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_x           <= '0;
            o_y           <= '0;
            o_de          <= 1'b0;
            o_err_h       <= 1'b0;
            o_err_v       <= 1'b0;
            o_probe_rgb   <= '0;
            o_probe_valid <= 1'b0;
        end else begin
            o_de          <= de_next;
            o_x           <= de_next ? x_next : '0;
            o_y           <= de_next ? y_next : '0;
            o_err_h       <= err_h;
            o_err_v       <= err_v;
            o_probe_valid <= probe_hit;
            if (probe_hit) o_probe_rgb <= rgb_r2;
        end
    end

    // Per-frame checksum: publish at each locked reload, restart on any state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            o_frame_sum  <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= (state == LOCKED) && reload;
            if ((state == LOCKED) && reload) begin
                o_frame_sum <= acc;
                acc         <= '0;
            end else if (state_next != state) begin
                acc <= '0;
            end else if (de_next) begin
                acc <= acc + SUM_W'(rgb_r2);
            end
        end
    end
endmodule
